// File: rtl/sys_defs.sv
// Shared memory-bus definitions: bus command encodings, requester/tag
// sizing and the owner-table entry type used by mem_bus_arbiter.
package sys_defs;

  localparam int NUM_MEM_REQ  = 2;
  localparam int MEM_TAG_W    = 4;
  localparam int MEM_REQ_ID_W =
    (NUM_MEM_REQ > 1) ? $clog2(NUM_MEM_REQ) : 1;

  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_LOAD  = 2'h1;
  localparam logic [1:0] BUS_STORE = 2'h2;

  typedef logic [MEM_REQ_ID_W-1:0] MEM_REQ_ID;

  typedef struct packed {
    logic      valid;
    MEM_REQ_ID id;
  } MEM_OWNER_ENTRY_t;

endpackage

// File: rtl/mem_tag_table.sv
// Owner table: maps each outstanding load tag to the requester that owns it.
// Ports: clock/reset (sync, active-low); alloc_en/alloc_tag/alloc_id write
// one entry; lkp_tag looks up and frees an entry (lkp_hit/lkp_id);
// tag_err is sticky on unowned completions or early tag reuse.
module mem_tag_table
  import sys_defs::*;
#(
  parameter int TAG_W = MEM_TAG_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_tag,
  input  MEM_REQ_ID        alloc_id,
  input  logic [TAG_W-1:0] lkp_tag,
  output logic             lkp_hit,
  output MEM_REQ_ID        lkp_id,
  output logic             tag_err
);

  localparam int DEPTH = 1 << TAG_W;

  MEM_OWNER_ENTRY_t table_q [DEPTH];
  MEM_OWNER_ENTRY_t table_d [DEPTH];
  logic             err_q;
  logic             err_d;

  always_comb begin
    lkp_hit = (lkp_tag != '0) && table_q[lkp_tag].valid;
    lkp_id  = table_q[lkp_tag].id;
  end

  always_comb begin
    table_d = table_q;
    err_d   = err_q;
    if (lkp_tag != '0) begin
      if (table_q[lkp_tag].valid) table_d[lkp_tag].valid = 1'b0;
      else                        err_d = 1'b1;
    end
    // Free happens first, so a same-cycle complete+alloc of one tag
    // is a clean handover rather than an early reuse.
    if (alloc_en && (alloc_tag != '0)) begin
      if (table_d[alloc_tag].valid) err_d = 1'b1;
      table_d[alloc_tag] = '{valid: 1'b1, id: alloc_id};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
      err_q <= 1'b0;
    end else begin
      table_q <= table_d;
      err_q   <= err_d;
    end
  end

  assign tag_err = err_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one proc2mem/mem2proc port between MSHR (0) and Icache (1).
// Ports: req_* per-requester command/addr/data in, response/tag lanes out;
// proc2mem_* to memory, mem2proc_* from memory; tag_err sticky.
// Build option MEM_ARB_RR_EN: round-robin instead of fixed priority.
module mem_bus_arbiter
  import sys_defs::*;
#(
  parameter int NUM_REQ = NUM_MEM_REQ,
  parameter int TAG_W   = MEM_TAG_W,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0][1:0]       req_command,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0][TAG_W-1:0] req_response,
  output logic [NUM_REQ-1:0][TAG_W-1:0] req_tag,
  output logic [DATA_W-1:0]             req_data_out,
  output logic [1:0]                    proc2mem_command,
  output logic [ADDR_W-1:0]             proc2mem_addr,
  output logic [DATA_W-1:0]             proc2mem_data,
  input  logic [TAG_W-1:0]              mem2proc_response,
  input  logic [TAG_W-1:0]              mem2proc_tag,
  input  logic [DATA_W-1:0]             mem2proc_data,
  output logic                          tag_err
);

  logic      gnt_valid;
  MEM_REQ_ID gnt_id;
  logic      accept;
  logic      alloc_en;
  logic      lkp_hit;
  MEM_REQ_ID lkp_id;

  assign accept = reset && gnt_valid && (mem2proc_response != '0);
  assign alloc_en = accept && (req_command[gnt_id] == BUS_LOAD);

`ifdef MEM_ARB_RR_EN
  MEM_REQ_ID last_grant_q;
  MEM_REQ_ID last_grant_d;

  always_comb begin
    int idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(last_grant_q) + 1 + k) % NUM_REQ;
      if (!gnt_valid && (req_command[idx] != BUS_NONE)) begin
        gnt_valid = 1'b1;
        gnt_id    = MEM_REQ_ID'(idx);
      end
    end
  end

  // A rejected grantee keeps its turn: only acceptance advances.
  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) last_grant_d = gnt_id;
  end

  always_ff @(posedge clock) begin
    if (!reset) last_grant_q <= MEM_REQ_ID'(NUM_REQ - 1);
    else        last_grant_q <= last_grant_d;
  end
`else
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_valid && (req_command[k] != BUS_NONE)) begin
        gnt_valid = 1'b1;
        gnt_id    = MEM_REQ_ID'(k);
      end
    end
  end
`endif

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    req_response     = '0;
    req_tag          = '0;
    if (gnt_valid) begin
      proc2mem_addr = req_addr[gnt_id];
      proc2mem_data = req_data[gnt_id];
      if (reset) proc2mem_command = req_command[gnt_id];
    end
    if (accept) req_response[gnt_id] = mem2proc_response;
    if (reset && lkp_hit) req_tag[lkp_id] = mem2proc_tag;
  end

  assign req_data_out = mem2proc_data;

  mem_tag_table #(
    .TAG_W (TAG_W)
  ) u_tag_table (
    .clock     (clock),
    .reset     (reset),
    .alloc_en  (alloc_en),
    .alloc_tag (mem2proc_response),
    .alloc_id  (gnt_id),
    .lkp_tag   (mem2proc_tag),
    .lkp_hit   (lkp_hit),
    .lkp_id    (lkp_id),
    .tag_err   (tag_err)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table, directed
// multi-cycle sequences and randomized traffic against a reference model.
module tb_mem_bus_arbiter;
  import sys_defs::*;

  logic              clock;
  logic              reset;
  logic [1:0][1:0]   req_command;
  logic [1:0][63:0]  req_addr;
  logic [1:0][63:0]  req_data;
  logic [1:0][3:0]   req_response;
  logic [1:0][3:0]   req_tag;
  logic [63:0]       req_data_out;
  logic [1:0]        proc2mem_command;
  logic [63:0]       proc2mem_addr;
  logic [63:0]       proc2mem_data;
  logic [3:0]        mem2proc_response;
  logic [3:0]        mem2proc_tag;
  logic [63:0]       mem2proc_data;
  logic              tag_err;

  mem_bus_arbiter #(
    .NUM_REQ (2), .TAG_W (4), .ADDR_W (64), .DATA_W (64)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .req_command       (req_command),
    .req_addr          (req_addr),
    .req_data          (req_data),
    .req_response      (req_response),
    .req_tag           (req_tag),
    .req_data_out      (req_data_out),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .mem2proc_response (mem2proc_response),
    .mem2proc_tag      (mem2proc_tag),
    .mem2proc_data     (mem2proc_data),
    .tag_err           (tag_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
  int eg [4] = '{0, 1, 0, 1};
`else
  localparam bit RR = 1'b0;
  int eg [4] = '{0, 0, 0, 0};
`endif

  typedef struct {
    logic [1:0]  c0, c1;
    logic [63:0] a0, a1;
    logic [3:0]  rsp, mt;
    logic [63:0] md;
    logic [1:0]  e_cmd;
    logic [63:0] e_addr;
    logic [7:0]  e_rsp, e_tag;
    logic        e_err;
  } vec_t;

  vec_t vt [14];

  function automatic vec_t mk(
    input logic [1:0] c0, c1, input logic [63:0] a0, a1,
    input logic [3:0] rsp, mt, input logic [63:0] md,
    input logic [1:0] e_cmd, input logic [63:0] e_addr,
    input logic [7:0] e_rsp, e_tag, input logic e_err);
    vec_t v;
    v = '{c0, c1, a0, a1, rsp, mt, md, e_cmd, e_addr, e_rsp, e_tag, e_err};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] c0, c1,
                       input logic [63:0] a0, a1, d0, d1,
                       input logic [3:0] rsp, mt,
                       input logic [63:0] md);
    req_command[0]    = c0;
    req_command[1]    = c1;
    req_addr[0]       = a0;
    req_addr[1]       = a1;
    req_data[0]       = d0;
    req_data[1]       = d1;
    mem2proc_response = rsp;
    mem2proc_tag      = mt;
    mem2proc_data     = md;
  endtask

  task automatic idle(input logic [3:0] mt);
    drive(BUS_NONE, BUS_NONE, 0, 0, 0, 0, 4'h0, mt, 64'h0);
  endtask

  task automatic settle;
    #3;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    idle(4'h0);
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Reference model state
  bit          m_valid [16];
  int          m_id    [16];
  bit          m_err;
  int          m_last;
  logic [1:0]  rc [2];
  logic [63:0] ra [2];
  logic [63:0] rd [2];

  initial begin
    logic [3:0]  rsp, mt;
    logic [63:0] md;
    int          g, idx;
    bit          acc, hit;
    logic [7:0]  ersp, etag;

    vt[0]  = mk(BUS_LOAD, BUS_NONE, 64'h100, 0, 4'd3, 4'd0, 0,
                BUS_LOAD, 64'h100, 8'h03, 8'h00, 1'b0);
    vt[1]  = mk(BUS_NONE, BUS_NONE, 0, 0, 4'd0, 4'd0, 0,
                BUS_NONE, 0, 8'h00, 8'h00, 1'b0);
    vt[2]  = vt[1];
    vt[3]  = vt[1];
    vt[4]  = vt[1];
    vt[5]  = mk(BUS_NONE, BUS_NONE, 0, 0, 4'd0, 4'd3, 64'hDEAD,
                BUS_NONE, 0, 8'h00, 8'h03, 1'b0);
    vt[6]  = mk(BUS_NONE, BUS_LOAD, 0, 64'h200, 4'd0, 4'd0, 0,
                BUS_LOAD, 64'h200, 8'h00, 8'h00, 1'b0);
    vt[7]  = vt[6];
    vt[8]  = mk(BUS_NONE, BUS_LOAD, 0, 64'h200, 4'd7, 4'd0, 0,
                BUS_LOAD, 64'h200, 8'h70, 8'h00, 1'b0);
    vt[9]  = mk(BUS_NONE, BUS_NONE, 0, 0, 4'd0, 4'd7, 64'hBEEF,
                BUS_NONE, 0, 8'h00, 8'h70, 1'b0);
    vt[10] = mk(BUS_STORE, BUS_NONE, 64'h300, 0, 4'd2, 4'd0, 0,
                BUS_STORE, 64'h300, 8'h02, 8'h00, 1'b0);
    vt[11] = mk(BUS_NONE, BUS_NONE, 0, 0, 4'd0, 4'd2, 0,
                BUS_NONE, 0, 8'h00, 8'h00, 1'b0);
    vt[12] = mk(BUS_NONE, BUS_NONE, 0, 0, 4'd0, 4'd0, 0,
                BUS_NONE, 0, 8'h00, 8'h00, 1'b1);
    vt[13] = vt[12];

    // Reset held low: outputs forced quiet even with a live request
    reset = 1'b0;
    idle(4'h0);
    @(posedge clock);
    #1;
    drive(BUS_LOAD, BUS_NONE, 64'h40, 0, 0, 0, 4'd3, 4'd0, 0);
    settle();
    chk("rst_cmd_forced", proc2mem_command, BUS_NONE);
    chk("rst_rsp_forced", req_response, 8'h00);
    tick();
    reset = 1'b1;
    idle(4'h0);
    settle();
    chk("post_rst_cmd", proc2mem_command, BUS_NONE);
    chk("post_rst_err", tag_err, 1'b0);
    chk("post_rst_rsp", req_response, 8'h00);
    chk("post_rst_tag", req_tag, 8'h00);
    tick();

    for (int i = 0; i < 14; i++) begin
      drive(vt[i].c0, vt[i].c1, vt[i].a0, vt[i].a1, 0, 0,
            vt[i].rsp, vt[i].mt, vt[i].md);
      settle();
      chk($sformatf("vec%0d_cmd", i), proc2mem_command, vt[i].e_cmd);
      chk($sformatf("vec%0d_addr", i), proc2mem_addr, vt[i].e_addr);
      chk($sformatf("vec%0d_rsp", i), req_response, vt[i].e_rsp);
      chk($sformatf("vec%0d_tag", i), req_tag, vt[i].e_tag);
      chk($sformatf("vec%0d_err", i), tag_err, vt[i].e_err);
      chk($sformatf("vec%0d_dout", i), req_data_out, vt[i].md);
      tick();
    end

    // Mid-operation reset drops the outstanding tag
    drive(BUS_LOAD, BUS_NONE, 64'h900, 0, 0, 0, 4'd9, 4'd0, 0);
    settle();
    chk("mid_alloc_rsp", req_response, 8'h09);
    tick();
    do_reset();
    idle(4'd9);
    settle();
    chk("mid_drop_tag", req_tag, 8'h00);
    chk("mid_err_clear", tag_err, 1'b0);
    tick();
    idle(4'd0);
    settle();
    chk("mid_err_set", tag_err, 1'b1);
    tick();

    // Both requesters contend for 4 accepted cycles
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(BUS_LOAD, BUS_LOAD, 64'h10, 64'h20, 0, 0,
            4'(i + 1), 4'd0, 0);
      settle();
      chk($sformatf("arb%0d_addr", i), proc2mem_addr,
          (eg[i] == 1) ? 64'h20 : 64'h10);
      chk($sformatf("arb%0d_rsp", i), req_response,
          8'(i + 1) << (4 * eg[i]));
      tick();
    end

    // Same-cycle completion/allocation handover, then early reuse
    do_reset();
    drive(BUS_LOAD, BUS_NONE, 64'h500, 0, 0, 0, 4'd5, 4'd0, 0);
    settle();
    chk("ho_alloc0", req_response, 8'h05);
    tick();
    drive(BUS_NONE, BUS_LOAD, 0, 64'h600, 0, 0, 4'd5, 4'd5, 0);
    settle();
    chk("ho_old_owner", req_tag, 8'h05);
    chk("ho_alloc1", req_response, 8'h50);
    tick();
    idle(4'd5);
    settle();
    chk("ho_new_owner", req_tag, 8'h50);
    chk("ho_no_err", tag_err, 1'b0);
    tick();
    drive(BUS_LOAD, BUS_NONE, 64'h700, 0, 0, 0, 4'd6, 4'd0, 0);
    tick();
    drive(BUS_LOAD, BUS_NONE, 64'h700, 0, 0, 0, 4'd6, 4'd0, 0);
    settle();
    chk("reuse_pre_err", tag_err, 1'b0);
    tick();
    idle(4'd0);
    settle();
    chk("reuse_err", tag_err, 1'b1);
    tick();

    // Randomized traffic against the reference model
    do_reset();
    for (int t = 0; t < 16; t++) begin
      m_valid[t] = 1'b0;
      m_id[t]    = 0;
    end
    m_err  = 1'b0;
    m_last = 1;
    for (int n = 0; n < 400; n++) begin
      for (int r = 0; r < 2; r++) begin
        rc[r] = 2'($urandom_range(0, 2));
        ra[r] = {$urandom, $urandom};
        rd[r] = {$urandom, $urandom};
      end
      rsp = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      mt  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      md  = {$urandom, $urandom};
      drive(rc[0], rc[1], ra[0], ra[1], rd[0], rd[1], rsp, mt, md);
      settle();

      g = -1;
      for (int k = 0; k < 2; k++) begin
        idx = RR ? (m_last + 1 + k) % 2 : k;
        if (g < 0 && rc[idx] != BUS_NONE) g = idx;
      end
      acc  = (g >= 0) && (rsp != 0);
      hit  = (mt != 0) && m_valid[mt];
      ersp = acc ? (8'(rsp) << (4 * g)) : 8'h00;
      etag = hit ? (8'(mt) << (4 * m_id[mt])) : 8'h00;

      chk("rnd_cmd", proc2mem_command, (g >= 0) ? rc[g] : BUS_NONE);
      chk("rnd_addr", proc2mem_addr, (g >= 0) ? ra[g] : 64'h0);
      chk("rnd_data", proc2mem_data, (g >= 0) ? rd[g] : 64'h0);
      chk("rnd_rsp", req_response, ersp);
      chk("rnd_tag", req_tag, etag);
      chk("rnd_err", tag_err, m_err);

      if (mt != 0) begin
        if (m_valid[mt]) m_valid[mt] = 1'b0;
        else             m_err = 1'b1;
      end
      if (acc && rc[g] == BUS_LOAD) begin
        if (m_valid[rsp]) m_err = 1'b1;
        m_valid[rsp] = 1'b1;
        m_id[rsp]    = g;
      end
      if (acc) m_last = g;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
